// File: rtl/mic_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// mic_frame_buffer_if
//   Bundles the sample input strobe and the frame output handshake of the
//   microphone frame buffer.
//
//   Signals:
//     sample_valid  one-cycle strobe, sample_data is valid in that cycle
//     sample_data   CHANNELS*WIDTH, channel c at [c*WIDTH +: WIDTH]
//     frame_valid   a completed frame is presented on frame_data
//     frame_ready   downstream accepts the presented frame
//     frame_data    SAMPLES*CHANNELS*WIDTH, element (s,c) at
//                   [(s*CHANNELS+c)*WIDTH +: WIDTH], s=0 newest
//
//   Handshake: a frame transfers on a rising clock edge where frame_valid and
//   frame_ready are both high. Once frame_valid is raised, frame_valid and
//   frame_data hold until that transfer; the only exception is enable being
//   dropped, which withdraws the frame. frame_ready may be driven freely and
//   has no effect while frame_valid is low. sample_valid has no back-pressure:
//   the producer never waits.
//
//   Modports: slave = the frame buffer, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface mic_frame_buffer_if #(
    parameter int SAMPLES  = 16,
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    logic                                sample_valid;
    logic [CHANNELS*WIDTH-1:0]           sample_data;
    logic                                frame_valid;
    logic                                frame_ready;
    logic [SAMPLES*CHANNELS*WIDTH-1:0]   frame_data;

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  frame_ready,
        output frame_valid,
        output frame_data
    );

    modport master (
        output sample_valid,
        output sample_data,
        output frame_ready,
        input  frame_valid,
        input  frame_data
    );
endinterface

// File: rtl/mic_frame_buffer.sv
// -----------------------------------------------------------------------------
// mic_frame_buffer
//   Collects SAMPLES-deep windows of CHANNELS parallel microphone streams and
//   presents each completed window as one frame. Block mode emits
//   non-overlapping frames; sliding mode emits a frame every HOP samples once
//   the window is full. Samples arriving while a frame is held are dropped and
//   counted in a saturating overrun counter.
//
//   Ports:
//     adc_clk        clock, all logic on the rising edge
//     reset_n        asynchronous active-low reset
//     enable         run control, low forces IDLE
//     mode           0 = block, 1 = sliding, sampled on IDLE->FILL
//     bus            mic_frame_buffer_if.slave (sample strobe + frame handshake)
//     fill_level     number of valid samples in the window
//     overrun_count  dropped samples, saturating, cleared only by reset
//     o_dbg_state    current FSM state (0 IDLE, 1 FILL, 2 PRESENT)
// -----------------------------------------------------------------------------
module mic_frame_buffer #(
    parameter int SAMPLES  = 16,
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int HOP      = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         adc_clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         mode,
    mic_frame_buffer_if.slave            bus,
    output logic [$clog2(SAMPLES+1)-1:0] fill_level,
    output logic [CNT_W-1:0]             overrun_count,
    output logic [1:0]                   o_dbg_state
);
    localparam int FILL_W = $clog2(SAMPLES + 1);
    localparam int CW     = CHANNELS * WIDTH;
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(SAMPLES);
    localparam logic [FILL_W-1:0] HOP_V = FILL_W'(HOP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   r_hop;
    logic [CNT_W-1:0]    r_ovr;
    logic [CW-1:0]       r_win [SAMPLES];

    state_t              w_state_nxt;
    logic                w_mode_nxt;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [FILL_W-1:0]   w_hop_nxt;
    logic [FILL_W-1:0]   w_fill_base;
    logic [FILL_W-1:0]   w_hop_base;
    logic [FILL_W-1:0]   w_fill_sh;
    logic [FILL_W-1:0]   w_hop_sh;
    logic                w_accept;
    logic                w_ovr_inc;
    logic [SAMPLES*CW-1:0] w_frame;

    // Next-state / control. w_fill_base and w_hop_base are the counter values
    // a newly accepted sample builds on: the current values in FILL, or the
    // post-handshake values when a sample arrives together with frame_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_fill_nxt  = r_fill;
        w_hop_nxt   = r_hop;
        w_fill_base = r_fill;
        w_hop_base  = r_hop;
        w_fill_sh   = '0;
        w_hop_sh    = '0;
        w_accept    = 1'b0;
        w_ovr_inc   = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_fill_nxt  = '0;
            w_hop_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FILL;
                    w_mode_nxt  = mode;
                    w_fill_nxt  = '0;
                    w_hop_nxt   = '0;
                end
                ST_FILL: begin
                    w_accept = bus.sample_valid;
                end
                ST_PRESENT: begin
                    if (bus.frame_ready) begin
                        w_state_nxt = ST_FILL;
                        w_fill_base = r_mode ? FULL : '0;
                        w_hop_base  = '0;
                        w_fill_nxt  = w_fill_base;
                        w_hop_nxt   = '0;
                        w_accept    = bus.sample_valid;
                    end else if (bus.sample_valid) begin
                        w_ovr_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_accept) begin
                w_fill_sh = (w_fill_base == FULL) ? FULL : w_fill_base + 1'b1;
                w_hop_sh  = w_hop_base + 1'b1;
                // First time the window fills, the hop counter is forced so
                // the first sliding frame comes out immediately.
                if ((w_fill_base != FULL) && (w_fill_sh == FULL)) begin
                    w_hop_sh = HOP_V;
                end
                w_fill_nxt = w_fill_sh;
                w_hop_nxt  = w_hop_sh;
                if ((w_fill_sh == FULL) && (!r_mode || (w_hop_sh >= HOP_V))) begin
                    w_state_nxt = ST_PRESENT;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_fill  <= '0;
            r_hop   <= '0;
            r_ovr   <= '0;
            for (int k = 0; k < SAMPLES; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_fill  <= w_fill_nxt;
            r_hop   <= w_hop_nxt;
            if (w_ovr_inc && (r_ovr != {CNT_W{1'b1}})) begin
                r_ovr <= r_ovr + 1'b1;
            end
            if (w_accept) begin
                for (int k = SAMPLES - 1; k > 0; k--) begin
                    r_win[k] <= r_win[k-1];
                end
                r_win[0] <= bus.sample_data;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            w_frame[s*CW +: CW] = r_win[s];
        end
    end

    assign bus.frame_valid = (r_state == ST_PRESENT);
    assign bus.frame_data  = w_frame;
    assign fill_level      = r_fill;
    assign overrun_count   = r_ovr;
    assign o_dbg_state     = r_state;

endmodule
